// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU sequencer: commands, FSM states, ALU operation
// codes and the command-to-ALU-control mapping.
package alu_ctrl_pkg;

  typedef enum logic [2:0] {
    CMD_AND = 3'd0,
    CMD_OR  = 3'd1,
    CMD_ADD = 3'd2,
    CMD_SUB = 3'd3,
    CMD_SLT = 3'd4,
    CMD_NOR = 3'd5,
    CMD_MUL = 3'd6,
    CMD_DIV = 3'd7
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EXEC = 3'd1,
    ST_MUL  = 3'd2,
    ST_DIV  = 3'd3,
    ST_FIN  = 3'd4
  } state_e;

  localparam logic [1:0] OPR_AND     = 2'd0;
  localparam logic [1:0] OPR_OR      = 2'd1;
  localparam logic [1:0] OPR_ADD_SUB = 2'd2;
  localparam logic [1:0] OPR_SLT     = 2'd3;

  typedef struct packed {
    logic       ainv;
    logic       bneg;
    logic [1:0] opr;
  } alu_ctl_t;

  // MUL/DIV never use this mapping directly; they fall back to AND.
  function automatic alu_ctl_t cmd_to_ctl(input cmd_e cmd);
    alu_ctl_t ctl;
    ctl = '{ainv: 1'b0, bneg: 1'b0, opr: OPR_AND};
    case (cmd)
      CMD_OR:  ctl.opr = OPR_OR;
      CMD_ADD: ctl.opr = OPR_ADD_SUB;
      CMD_SUB: begin ctl.bneg = 1'b1; ctl.opr = OPR_ADD_SUB; end
      CMD_SLT: begin ctl.bneg = 1'b1; ctl.opr = OPR_SLT;     end
      CMD_NOR: begin ctl.ainv = 1'b1; ctl.bneg = 1'b1;       end
      default: ;
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/alu_4_bit.sv
// 4-bit ripple ALU: optional A inversion, B negation (carry-in = BNEG),
// and AND / OR / ADD / SLT result selection.
module alu_4_bit
  import alu_ctrl_pkg::*;
(
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_ainv,
  input  logic       i_bneg,
  input  logic [1:0] i_opr,
  output logic [3:0] o_result,
  output logic       o_overflow,
  output logic       o_cout
);

  logic [3:0] w_a;
  logic [3:0] w_b;
  logic [3:0] w_sum;
  logic [4:0] w_carry;
  logic       w_set;

  assign w_carry[0] = i_bneg;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_bit
      assign w_a[gi]         = i_a[gi] ^ i_ainv;
      assign w_b[gi]         = i_b[gi] ^ i_bneg;
      assign w_sum[gi]       = w_a[gi] ^ w_b[gi] ^ w_carry[gi];
      assign w_carry[gi + 1] = (w_a[gi] & w_b[gi]) | (w_carry[gi] & (w_a[gi] ^ w_b[gi]));
    end
  endgenerate

  assign o_overflow = w_carry[3] ^ w_carry[4];
  assign o_cout     = w_carry[4];
  // Sign of the true difference, corrected for overflow.
  assign w_set      = w_sum[3] ^ o_overflow;

  always_comb begin
    o_result = w_a & w_b;
    case (i_opr)
      OPR_OR:      o_result = w_a | w_b;
      OPR_ADD_SUB: o_result = w_sum;
      OPR_SLT:     o_result = {3'b000, w_set};
      default:     o_result = w_a & w_b;
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Command sequencer around one alu_4_bit: single-pass logic/arith ops plus
// iterative shift-add multiply and restoring divide.
module alu_seq_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int ITER = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic [2:0] CMD,
  input  logic [3:0] OPA,
  input  logic [3:0] OPB,
  output logic       READY,
  output logic       DONE,
  output logic [3:0] RES_LO,
  output logic [3:0] RES_HI,
  output logic       ZERO,
  output logic       OVERFLOW,
  output logic       COUT,
  output logic       DIV0
);

  localparam int CW = $clog2(ITER);

  state_e      r_state;
  state_e      w_state_next;
  cmd_e        r_cmd;
  logic [3:0]  r_opa;
  logic [3:0]  r_opb;
  logic [3:0]  r_hi;
  logic [3:0]  r_lo;
  logic [CW-1:0] r_iter;
  logic [3:0]  r_res_lo;
  logic [3:0]  r_res_hi;
  logic        r_zero;
  logic        r_ovf;
  logic        r_cout;
  logic        r_div0;

  alu_ctl_t    w_ctl;
  logic [3:0]  w_alu_a;
  logic [3:0]  w_alu_b;
  logic [3:0]  w_alu_result;
  logic        w_alu_ovf;
  logic        w_alu_cout;
  logic        w_last;
  logic [3:0]  w_div_t;
  logic        w_div_sub;
  logic [3:0]  w_div_r_next;
  logic [3:0]  w_div_q_next;
  logic [7:0]  w_mul_p_next;

  assign w_last  = (r_iter == CW'(ITER - 1));
  assign w_div_t = {r_hi[2:0], r_lo[3]};

  // ALU operand/control steering; r_hi/r_lo hold P in MUL and R/Q in DIV.
  always_comb begin
    w_alu_a = r_opa;
    w_alu_b = r_opb;
    w_ctl   = cmd_to_ctl(r_cmd);
    case (r_state)
      ST_MUL: begin
        w_alu_a = r_hi;
        w_ctl   = cmd_to_ctl(CMD_ADD);
      end
      ST_DIV: begin
        w_alu_a = w_div_t;
        w_ctl   = cmd_to_ctl(CMD_SUB);
      end
      default: ;
    endcase
  end

  alu_4_bit u_alu (
    .i_a        (w_alu_a),
    .i_b        (w_alu_b),
    .i_ainv     (w_ctl.ainv),
    .i_bneg     (w_ctl.bneg),
    .i_opr      (w_ctl.opr),
    .o_result   (w_alu_result),
    .o_overflow (w_alu_ovf),
    .o_cout     (w_alu_cout)
  );

  assign w_mul_p_next = r_lo[0] ? {w_alu_cout, w_alu_result, r_lo[3:1]}
                                : {1'b0, r_hi, r_lo[3:1]};
  // A set R[3] means the 5-bit partial remainder already exceeds any divisor.
  assign w_div_sub    = r_hi[3] | w_alu_cout;
  assign w_div_r_next = w_div_sub ? w_alu_result : w_div_t;
  assign w_div_q_next = {r_lo[2:0], w_div_sub};

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (START) begin
          case (cmd_e'(CMD))
            CMD_MUL: w_state_next = ST_MUL;
            CMD_DIV: w_state_next = (OPB == 4'd0) ? ST_EXEC : ST_DIV;
            default: w_state_next = ST_EXEC;
          endcase
        end
      end
      ST_EXEC: w_state_next = ST_FIN;
      ST_MUL,
      ST_DIV:  if (w_last) w_state_next = ST_FIN;
      ST_FIN:  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state  <= ST_IDLE;
      r_cmd    <= CMD_AND;
      r_opa    <= '0;
      r_opb    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_iter   <= '0;
      r_res_lo <= '0;
      r_res_hi <= '0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
      r_cout   <= 1'b0;
      r_div0   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_IDLE: begin
          if (START) begin
            r_cmd  <= cmd_e'(CMD);
            r_opa  <= OPA;
            r_opb  <= OPB;
            r_hi   <= '0;
            r_lo   <= OPA;
            r_iter <= '0;
          end
        end
        ST_EXEC: begin
          // DIV only reaches EXEC with a zero divisor.
          if (r_cmd == CMD_DIV) begin
            r_res_lo <= 4'hF;
            r_res_hi <= r_opa;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_cout   <= 1'b0;
            r_div0   <= 1'b1;
          end else begin
            r_res_lo <= w_alu_result;
            r_res_hi <= 4'd0;
            r_zero   <= (w_alu_result == 4'd0);
            r_ovf    <= w_alu_ovf;
            r_cout   <= w_alu_cout;
            r_div0   <= 1'b0;
          end
        end
        ST_MUL: begin
          {r_hi, r_lo} <= w_mul_p_next;
          r_iter       <= r_iter + 1'b1;
          if (w_last) begin
            r_res_hi <= w_mul_p_next[7:4];
            r_res_lo <= w_mul_p_next[3:0];
            r_zero   <= (w_mul_p_next == 8'd0);
            r_ovf    <= 1'b0;
            r_cout   <= 1'b0;
            r_div0   <= 1'b0;
          end
        end
        ST_DIV: begin
          r_hi   <= w_div_r_next;
          r_lo   <= w_div_q_next;
          r_iter <= r_iter + 1'b1;
          if (w_last) begin
            r_res_hi <= w_div_r_next;
            r_res_lo <= w_div_q_next;
            r_zero   <= (w_div_q_next == 4'd0);
            r_ovf    <= 1'b0;
            r_cout   <= 1'b0;
            r_div0   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign READY    = (r_state == ST_IDLE);
  assign DONE     = (r_state == ST_FIN);
  assign RES_LO   = r_res_lo;
  assign RES_HI   = r_res_hi;
  assign ZERO     = r_zero;
  assign OVERFLOW = r_ovf;
  assign COUT     = r_cout;
  assign DIV0     = r_div0;

endmodule
